// File: rtl/ldst_port_sched.sv
// ldst_port_sched: round-robin scheduler for the shared load/store memory port.
// A winning request's length/stride/base are captured in IDLE, RUN issues one
// beat per accepted cycle at base + k*stride, and DONE emits a one-cycle
// end-of-access pulse before returning to IDLE.
module ldst_port_sched #(
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_LEN  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Stall,
  input  logic                  I_Ld_Req,
  input  logic [WIDTH_LEN-1:0]  I_Ld_Length,
  input  logic [WIDTH_ADDR-1:0] I_Ld_Stride,
  input  logic [WIDTH_ADDR-1:0] I_Ld_Base,
  input  logic                  I_St_Req,
  input  logic [WIDTH_LEN-1:0]  I_St_Length,
  input  logic [WIDTH_ADDR-1:0] I_St_Stride,
  input  logic [WIDTH_ADDR-1:0] I_St_Base,
  input  logic                  I_Mem_Ready,
  output logic                  O_Ld_Grant,
  output logic                  O_St_Grant,
  output logic                  O_Mem_Req,
  output logic                  O_Mem_Store,
  output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
  output logic                  O_End_Access
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_owner;    // 0 = load burst, 1 = store burst
  logic                  r_last_st;  // owner of the most recently started burst
  logic [WIDTH_LEN-1:0]  r_len;
  logic [WIDTH_LEN-1:0]  r_cnt;
  logic [WIDTH_ADDR-1:0] r_stride;
  logic [WIDTH_ADDR-1:0] r_addr;

  logic                  w_run;
  logic                  w_cnt_done;
  logic                  w_fire;
  logic                  w_win;
  logic                  w_pick_st;
  logic [WIDTH_LEN-1:0]  w_cnt_inc;

  assign w_run      = (r_state == S_RUN);
  assign w_cnt_done = (r_cnt == r_len);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_win      = I_Ld_Req | I_St_Req;
  // Store wins when it is alone, or when both request and load went last.
  assign w_pick_st  = I_St_Req & (~I_Ld_Req | ~r_last_st);
  assign w_fire     = O_Mem_Req & I_Mem_Ready;

  // Scheduler FSM: arbitration, operand capture and beat sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last_st <= 1'b1;
      r_len     <= '0;
      r_cnt     <= '0;
      r_stride  <= '0;
      r_addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win) begin
            r_owner   <= w_pick_st;
            r_last_st <= w_pick_st;
            r_len     <= w_pick_st ? I_St_Length : I_Ld_Length;
            r_stride  <= w_pick_st ? I_St_Stride : I_Ld_Stride;
            r_addr    <= w_pick_st ? I_St_Base   : I_Ld_Base;
            r_cnt     <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_fire) begin
            r_addr <= r_addr + r_stride;
            r_cnt  <= w_cnt_inc;
          end
          // Leave right after the final beat, or at once for a zero-length burst.
          if (w_cnt_done || (w_fire && (w_cnt_inc == r_len))) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decodes of registered state; only O_Mem_Req sees I_Stall directly.
  assign O_Ld_Grant   = w_run & ~r_owner;
  assign O_St_Grant   = w_run &  r_owner;
  assign O_Mem_Req    = w_run & ~I_Stall & ~w_cnt_done;
  assign O_Mem_Store  = w_run &  r_owner;
  assign O_Mem_Addr   = w_run ? r_addr : '0;
  assign O_End_Access = (r_state == S_DONE);

endmodule

// File: tb/tb_ldst_port_sched.sv
// Directed bench for ldst_port_sched: each cycle the full output vector
// {ld_grant, st_grant, mem_req, mem_store, end_access, addr} is compared
// with a hand-computed value.
module tb_ldst_port_sched;

  logic        clock;
  logic        reset;
  logic        I_Stall;
  logic        I_Ld_Req;
  logic [15:0] I_Ld_Length;
  logic [31:0] I_Ld_Stride;
  logic [31:0] I_Ld_Base;
  logic        I_St_Req;
  logic [15:0] I_St_Length;
  logic [31:0] I_St_Stride;
  logic [31:0] I_St_Base;
  logic        I_Mem_Ready;
  logic        O_Ld_Grant;
  logic        O_St_Grant;
  logic        O_Mem_Req;
  logic        O_Mem_Store;
  logic [31:0] O_Mem_Addr;
  logic        O_End_Access;

  int n_cmp;
  int n_fail;

  ldst_port_sched #(.WIDTH_ADDR(32), .WIDTH_LEN(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .I_Stall      (I_Stall),
    .I_Ld_Req     (I_Ld_Req),
    .I_Ld_Length  (I_Ld_Length),
    .I_Ld_Stride  (I_Ld_Stride),
    .I_Ld_Base    (I_Ld_Base),
    .I_St_Req     (I_St_Req),
    .I_St_Length  (I_St_Length),
    .I_St_Stride  (I_St_Stride),
    .I_St_Base    (I_St_Base),
    .I_Mem_Ready  (I_Mem_Ready),
    .O_Ld_Grant   (O_Ld_Grant),
    .O_St_Grant   (O_St_Grant),
    .O_Mem_Req    (O_Mem_Req),
    .O_Mem_Store  (O_Mem_Store),
    .O_Mem_Addr   (O_Mem_Addr),
    .O_End_Access (O_End_Access)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected vector: {ld_grant, st_grant, mem_req, mem_store, end_access, addr}
  function automatic logic [36:0] ev(input logic lg, input logic sg, input logic rq,
                                     input logic st, input logic ea, input logic [31:0] a);
    return {lg, sg, rq, st, ea, a};
  endfunction

  function automatic logic [36:0] ld_beat(input logic [31:0] a);
    return ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
  endfunction

  function automatic logic [36:0] st_beat(input logic [31:0] a);
    return ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a);
  endfunction

  function automatic logic [36:0] idle_v();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endfunction

  function automatic logic [36:0] done_v();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endfunction

  // Advance to 1ns after the next rising edge; inputs are then driven here.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle after input changes, then compare.
  task automatic ck(input string tag, input logic [36:0] e);
    logic [36:0] obs;
    #1;
    obs = {O_Ld_Grant, O_St_Grant, O_Mem_Req, O_Mem_Store, O_End_Access, O_Mem_Addr};
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    $display("cmp %-14s obs=%h exp=%h", tag, obs, e);
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    I_Stall     = 1'b0;
    I_Ld_Req    = 1'b0;
    I_Ld_Length = 16'd0;
    I_Ld_Stride = 32'h0;
    I_Ld_Base   = 32'h0;
    I_St_Req    = 1'b0;
    I_St_Length = 16'd0;
    I_St_Stride = 32'h0;
    I_St_Base   = 32'h0;
    I_Mem_Ready = 1'b1;

    // Reset state
    cyc(); cyc();
    ck("reset", idle_v());
    reset = 1'b0;
    cyc();
    ck("idle0", idle_v());

    // Single load: base 0x100, stride 4, len 3
    I_Ld_Req = 1'b1; I_Ld_Base = 32'h100; I_Ld_Stride = 32'd4; I_Ld_Length = 16'd3;
    ck("ld1_req", idle_v());
    cyc(); ck("ld1_b0", ld_beat(32'h100));
    cyc(); ck("ld1_b1", ld_beat(32'h104));
    cyc(); ck("ld1_b2", ld_beat(32'h108));
    cyc(); ck("ld1_done", done_v());
    cyc(); I_Ld_Req = 1'b0; ck("ld1_idle", idle_v());

    // Round-robin from reset: both requesting, len 2 each
    reset = 1'b1;
    cyc(); reset = 1'b0;
    I_Ld_Req = 1'b1; I_Ld_Base = 32'h200; I_Ld_Stride = 32'd1; I_Ld_Length = 16'd2;
    I_St_Req = 1'b1; I_St_Base = 32'h300; I_St_Stride = 32'd2; I_St_Length = 16'd2;
    ck("rr_idle0", idle_v());
    cyc(); ck("rr_ld_b0", ld_beat(32'h200));
    cyc(); ck("rr_ld_b1", ld_beat(32'h201));
    cyc(); ck("rr_ld_done", done_v());
    cyc(); ck("rr_idle1", idle_v());
    cyc(); ck("rr_st_b0", st_beat(32'h300));
    cyc(); ck("rr_st_b1", st_beat(32'h302));
    cyc(); ck("rr_st_done", done_v());
    cyc(); ck("rr_idle2", idle_v());
    cyc(); ck("rr_ld2_b0", ld_beat(32'h200));
    cyc(); ck("rr_ld2_b1", ld_beat(32'h201));
    cyc(); ck("rr_ld2_done", done_v());
    cyc(); I_Ld_Req = 1'b0; I_St_Req = 1'b0; ck("rr_idle3", idle_v());

    // Backpressure and stall: len 4, base 0x40, stride 0x10
    I_Ld_Req = 1'b1; I_Ld_Base = 32'h40; I_Ld_Stride = 32'h10; I_Ld_Length = 16'd4;
    cyc(); ck("bp_b0", ld_beat(32'h40));
    cyc(); I_Mem_Ready = 1'b0; ck("bp_b1_wait0", ld_beat(32'h50));
    cyc(); ck("bp_b1_wait1", ld_beat(32'h50));
    cyc(); I_Mem_Ready = 1'b1; ck("bp_b1_fire", ld_beat(32'h50));
    cyc(); I_Stall = 1'b1; ck("bp_b2_stall", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h60));
    cyc(); I_Stall = 1'b0; ck("bp_b2_fire", ld_beat(32'h60));
    cyc(); ck("bp_b3", ld_beat(32'h70));
    cyc(); ck("bp_done", done_v());
    cyc(); I_Ld_Req = 1'b0; ck("bp_idle", idle_v());

    // Length 0 store: one grant cycle, no beat
    I_St_Req = 1'b1; I_St_Base = 32'h55; I_St_Stride = 32'd4; I_St_Length = 16'd0;
    cyc(); ck("len0_run", ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h55));
    cyc(); ck("len0_done", done_v());
    cyc(); I_St_Req = 1'b0; ck("len0_idle", idle_v());

    // Address wrap: base 0xFFFFFFFC, stride 8, len 2
    I_Ld_Req = 1'b1; I_Ld_Base = 32'hFFFF_FFFC; I_Ld_Stride = 32'd8; I_Ld_Length = 16'd2;
    cyc(); ck("wrap_b0", ld_beat(32'hFFFF_FFFC));
    cyc(); ck("wrap_b1", ld_beat(32'h0000_0004));
    cyc(); ck("wrap_done", done_v());
    cyc(); I_Ld_Req = 1'b0; ck("wrap_idle", idle_v());

    // Negative stride: store base 0x10, stride -4, len 3
    I_St_Req = 1'b1; I_St_Base = 32'h10; I_St_Stride = 32'hFFFF_FFFC; I_St_Length = 16'd3;
    cyc(); ck("neg_b0", st_beat(32'h10));
    cyc(); ck("neg_b1", st_beat(32'h0C));
    cyc(); ck("neg_b2", st_beat(32'h08));
    cyc(); ck("neg_done", done_v());
    cyc(); I_St_Req = 1'b0; ck("neg_idle", idle_v());

    // Operands change mid-burst: captured values must be used
    I_Ld_Req = 1'b1; I_Ld_Base = 32'h1000; I_Ld_Stride = 32'h20; I_Ld_Length = 16'd3;
    cyc(); I_Ld_Base = 32'hDEAD_0000; I_Ld_Stride = 32'h7; I_Ld_Length = 16'd9;
    ck("opchg_b0", ld_beat(32'h1000));
    cyc(); ck("opchg_b1", ld_beat(32'h1020));
    cyc(); ck("opchg_b2", ld_beat(32'h1040));
    cyc(); ck("opchg_done", done_v());
    cyc(); I_Ld_Req = 1'b0; ck("opchg_idle", idle_v());

    // Reset mid-burst: len 5, reset after beat 2, then a fresh store
    I_Ld_Req = 1'b1; I_Ld_Base = 32'h500; I_Ld_Stride = 32'd4; I_Ld_Length = 16'd5;
    cyc(); ck("rst_b0", ld_beat(32'h500));
    cyc(); ck("rst_b1", ld_beat(32'h504));
    cyc(); reset = 1'b1; I_Ld_Req = 1'b0; ck("rst_b2", ld_beat(32'h508));
    cyc(); reset = 1'b0; ck("rst_after0", idle_v());
    I_St_Req = 1'b1; I_St_Base = 32'h700; I_St_Stride = 32'd1; I_St_Length = 16'd1;
    cyc(); ck("rst_st_b0", st_beat(32'h700));
    cyc(); ck("rst_st_done", done_v());
    cyc(); I_St_Req = 1'b0; ck("rst_st_idle", idle_v());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
